ppi_port_handshake_ctrl: RTL and testbench

- Sequencer for one EightBitPort buffer instance, i.e. one 8255 group port. Drives its ControlEnable and GroupControl.
- Holds the port's control word and implements Mode 0 (basic I/O) and Mode 1 (strobed I/O), with the STB/IBF and OBF/ACK handshakes and the INTR output.
- Sits between the CPU-side read/write decode and the port buffer. Exposes status to the CPU.

---
 rtl/ppi_port_handshake_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_ppi_port_handshake_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ppi_port_handshake_ctrl.sv
// Handshake sequencer for one 8255 group port.
// Holds the control word and runs Mode 0 (basic I/O) and Mode 1 (strobed I/O).
// Drives the port buffer's ControlEnable/GroupControl and reports status.
module ppi_port_handshake_ctrl #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       Clk,
    input  logic       ResetN,
    input  logic       WrStrobe,
    input  logic       RdStrobe,
    input  logic       CtrlSel,
    input  logic [7:0] CpuData,
    input  logic       StbN,
    input  logic       AckN,
    output logic       ControlEnable,
    output logic       GroupControl,
    output logic       LatchEn,
    output logic       Ibf,
    output logic       ObfN,
    output logic       Intr,
    output logic [7:0] StatusWord
);

    // Fewer than two stages would leave metastability exposed.
    localparam int unsigned SyncLen = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StFull,
        StRead,
        StWaitAck,
        StAcked
    } stateT;

    stateT stateQ, stateD;

    logic mode1Q, mode1D;
    logic dirInQ, dirInD;
    logic inteQ, inteD;
    logic overrunQ, overrunD;
    logic ceQ, ceD;
    logic gcQ, gcD;
    logic latchEnQ, latchEnD;
    logic ibfQ, ibfD;
    logic obfNQ, obfND;
    logic intrQ, intrD;

    logic [SyncLen-1:0] stbSync, ackSync;
    logic stbPrev, ackPrev;
    logic stbFall, stbRise, ackFall, ackRise;

    logic ctrlWr, dataWr, rdAcc, modeSet, bitSetReset;

    // Edges are registered after the prev stage so the handshake action lands on the
    // (SYNC_STAGES+1)th edge after the first sampling edge.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            stbSync <= '1;
            ackSync <= '1;
            stbPrev <= 1'b1;
            ackPrev <= 1'b1;
            stbFall <= 1'b0;
            stbRise <= 1'b0;
            ackFall <= 1'b0;
            ackRise <= 1'b0;
        end else begin
            stbSync <= {stbSync[SyncLen-2:0], StbN};
            ackSync <= {ackSync[SyncLen-2:0], AckN};
            stbPrev <= stbSync[SyncLen-1];
            ackPrev <= ackSync[SyncLen-1];
            stbFall <= stbPrev & ~stbSync[SyncLen-1];
            stbRise <= ~stbPrev & stbSync[SyncLen-1];
            ackFall <= ackPrev & ~ackSync[SyncLen-1];
            ackRise <= ~ackPrev & ackSync[SyncLen-1];
        end
    end

    // CPU access decode; a control write swallows any read in the same cycle.
    always_comb begin
        ctrlWr      = WrStrobe & CtrlSel;
        dataWr      = WrStrobe & ~CtrlSel;
        rdAcc       = RdStrobe & ~ctrlWr;
        modeSet     = ctrlWr & CpuData[7] & ~CpuData[6];
        bitSetReset = ctrlWr & ~CpuData[7] & (CpuData[3:1] == 3'b010);
    end

    // Next-state and registered-output logic for configuration and both handshakes.
    always_comb begin
        stateD   = stateQ;
        mode1D   = mode1Q;
        dirInD   = dirInQ;
        inteD    = inteQ;
        overrunD = overrunQ;
        ibfD     = ibfQ;
        obfND    = obfNQ;
        intrD    = intrQ;
        latchEnD = 1'b0;
        // Output direction keeps the buffer enabled continuously.
        ceD      = ~dirInQ;
        gcD      = ~dirInQ;

        if (modeSet) begin
            mode1D   = CpuData[5];
            dirInD   = CpuData[4];
            stateD   = StIdle;
            inteD    = 1'b0;
            overrunD = 1'b0;
            ibfD     = 1'b0;
            obfND    = 1'b1;
            intrD    = 1'b0;
            ceD      = ~CpuData[4];
            gcD      = ~CpuData[4];
        end else begin
            if (bitSetReset) begin
                inteD    = CpuData[0];
                overrunD = 1'b0;
            end

            if (dirInQ && !mode1Q) begin
                if (rdAcc) begin
                    ceD = 1'b1;
                end
            end else if (dirInQ && mode1Q) begin
                unique case (stateQ)
                    StIdle: begin
                        if (stbFall) begin
                            stateD   = StLatch;
                            latchEnD = 1'b1;
                            ceD      = 1'b1;
                        end else if (rdAcc) begin
                            // Stale-data read: pulse the buffer, stay idle.
                            ceD = 1'b1;
                        end
                    end
                    StLatch: begin
                        stateD = StFull;
                        ibfD   = 1'b1;
                        if (stbRise) begin
                            intrD = inteQ;
                        end
                    end
                    StFull: begin
                        if (stbFall) begin
                            overrunD = 1'b1;
                        end
                        if (rdAcc) begin
                            stateD = StRead;
                            intrD  = 1'b0;
                            ceD    = 1'b1;
                        end else if (stbRise) begin
                            intrD = inteQ;
                        end
                    end
                    StRead: begin
                        if (stbFall) begin
                            overrunD = 1'b1;
                        end
                        stateD = StIdle;
                        ibfD   = 1'b0;
                    end
                    default: begin
                        stateD = StIdle;
                    end
                endcase
            end else if (mode1Q) begin
                unique case (stateQ)
                    StIdle: begin
                        if (dataWr) begin
                            stateD = StWaitAck;
                            obfND  = 1'b0;
                            intrD  = 1'b0;
                        end
                    end
                    StWaitAck: begin
                        // A fresh write alongside an ack leaves new data pending.
                        if (dataWr) begin
                            obfND = 1'b0;
                        end else if (ackFall) begin
                            obfND  = 1'b1;
                            stateD = StAcked;
                        end
                    end
                    StAcked: begin
                        if (dataWr) begin
                            stateD = StWaitAck;
                            obfND  = 1'b0;
                            intrD  = 1'b0;
                        end else if (ackRise) begin
                            stateD = StIdle;
                            intrD  = inteQ;
                        end
                    end
                    default: begin
                        stateD = StIdle;
                    end
                endcase
            end

            // Disabling the interrupt drops Intr at once, overriding any handshake update.
            if (bitSetReset && !CpuData[0]) begin
                intrD = 1'b0;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            stateQ   <= StIdle;
            mode1Q   <= 1'b0;
            dirInQ   <= 1'b1;
            inteQ    <= 1'b0;
            overrunQ <= 1'b0;
            ceQ      <= 1'b0;
            gcQ      <= 1'b0;
            latchEnQ <= 1'b0;
            ibfQ     <= 1'b0;
            obfNQ    <= 1'b1;
            intrQ    <= 1'b0;
        end else begin
            stateQ   <= stateD;
            mode1Q   <= mode1D;
            dirInQ   <= dirInD;
            inteQ    <= inteD;
            overrunQ <= overrunD;
            ceQ      <= ceD;
            gcQ      <= gcD;
            latchEnQ <= latchEnD;
            ibfQ     <= ibfD;
            obfNQ    <= obfND;
            intrQ    <= intrD;
        end
    end

    // Status is a plain concatenation of registered bits.
    always_comb begin
        ControlEnable = ceQ;
        GroupControl  = gcQ;
        LatchEn       = latchEnQ;
        Ibf           = ibfQ;
        ObfN          = obfNQ;
        Intr          = intrQ;
        StatusWord    = {intrQ, inteQ, ibfQ, ~obfNQ, overrunQ, mode1Q, dirInQ, 1'b0};
    end

endmodule

// File: tb/tb_ppi_port_handshake_ctrl.sv
// Directed bench for ppi_port_handshake_ctrl with hand-computed expectations.
module tb_ppi_port_handshake_ctrl;

    logic       Clk = 1'b0;
    logic       ResetN = 1'b0;
    logic       WrStrobe = 1'b0;
    logic       RdStrobe = 1'b0;
    logic       CtrlSel = 1'b0;
    logic [7:0] CpuData = 8'h00;
    logic       StbN = 1'b1;
    logic       AckN = 1'b1;
    logic       ControlEnable, GroupControl, LatchEn, Ibf, ObfN, Intr;
    logic [7:0] StatusWord;

    int numChecks = 0;
    int numFails = 0;
    logic sawLatch;

    ppi_port_handshake_ctrl #(.SYNC_STAGES(2)) dut (
        .Clk(Clk),
        .ResetN(ResetN),
        .WrStrobe(WrStrobe),
        .RdStrobe(RdStrobe),
        .CtrlSel(CtrlSel),
        .CpuData(CpuData),
        .StbN(StbN),
        .AckN(AckN),
        .ControlEnable(ControlEnable),
        .GroupControl(GroupControl),
        .LatchEn(LatchEn),
        .Ibf(Ibf),
        .ObfN(ObfN),
        .Intr(Intr),
        .StatusWord(StatusWord)
    );

    always #5 Clk = ~Clk;

    task automatic checkVal(input string tag, input logic [7:0] got, input logic [7:0] exp);
        numChecks++;
        if (got !== exp) begin
            numFails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are then stable for sampling.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic tickWatch(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            if (LatchEn) sawLatch = 1'b1;
        end
    endtask

    task automatic ctrlWrite(input logic [7:0] v);
        CtrlSel = 1'b1;
        CpuData = v;
        WrStrobe = 1'b1;
        tick();
        WrStrobe = 1'b0;
        CtrlSel = 1'b0;
    endtask

    task automatic dataWrite();
        CtrlSel = 1'b0;
        CpuData = 8'h5A;
        WrStrobe = 1'b1;
        tick();
        WrStrobe = 1'b0;
    endtask

    task automatic cpuRead();
        RdStrobe = 1'b1;
        tick();
        RdStrobe = 1'b0;
    endtask

    initial begin
        // Power-on reset.
        #12;
        checkVal("reset_status", StatusWord, 8'h02);
        ResetN = 1'b1;
        tick();
        tick();

        // Mode 1 output handshake.
        ctrlWrite(8'hA0);
        checkVal("out_gc", {7'd0, GroupControl}, 8'h01);
        checkVal("out_ce", {7'd0, ControlEnable}, 8'h01);
        checkVal("out_status_cfg", StatusWord, 8'h04);
        ctrlWrite(8'h05);
        checkVal("out_status_inte", StatusWord, 8'h44);
        dataWrite();
        checkVal("out_obf_fall", {7'd0, ObfN}, 8'h00);
        checkVal("out_status_obf", StatusWord, 8'h54);
        ctrlWrite(8'hC0);
        checkVal("reserved_status", StatusWord, 8'h54);
        checkVal("reserved_ce_gc", {6'd0, ControlEnable, GroupControl}, 8'h03);
        AckN = 1'b0;
        tick();
        tick();
        tick();
        checkVal("ack_obf_e2", {7'd0, ObfN}, 8'h00);
        tick();
        checkVal("ack_obf_e3", {7'd0, ObfN}, 8'h01);
        AckN = 1'b1;
        tick();
        tick();
        tick();
        checkVal("ack_intr_e6", {7'd0, Intr}, 8'h00);
        tick();
        checkVal("ack_intr_e7", {7'd0, Intr}, 8'h01);
        checkVal("ack_status", StatusWord, 8'hC4);
        dataWrite();
        checkVal("rewrite_status", StatusWord, 8'h54);

        // Asynchronous reset mid-cycle.
        #3;
        ResetN = 1'b0;
        #1;
        checkVal("areset_ce_gc", {6'd0, ControlEnable, GroupControl}, 8'h00);
        checkVal("areset_hs", {5'd0, Ibf, ObfN, Intr}, 8'h02);
        checkVal("areset_status", StatusWord, 8'h02);
        #3;
        ResetN = 1'b1;
        tick();

        // Mode 1 input handshake.
        ctrlWrite(8'hB0);
        checkVal("in_status_cfg", StatusWord, 8'h06);
        checkVal("in_ce_gc", {6'd0, ControlEnable, GroupControl}, 8'h00);
        ctrlWrite(8'h05);
        checkVal("in_status_inte", StatusWord, 8'h46);
        StbN = 1'b0;
        tick();
        tick();
        tick();
        checkVal("stb_latch_e2", {7'd0, LatchEn}, 8'h00);
        tick();
        checkVal("stb_latch_e3", {6'd0, LatchEn, ControlEnable}, 8'h03);
        checkVal("stb_ibf_e3", {7'd0, Ibf}, 8'h00);
        tick();
        checkVal("stb_full_e4", {5'd0, LatchEn, ControlEnable, Ibf}, 8'h01);
        StbN = 1'b1;
        tick();
        tick();
        tick();
        checkVal("stb_intr_e7", {7'd0, Intr}, 8'h00);
        tick();
        checkVal("stb_intr_e8", {7'd0, Intr}, 8'h01);
        checkVal("full_status", StatusWord, 8'hE6);
        cpuRead();
        checkVal("read_pulse", {5'd0, Intr, ControlEnable, Ibf}, 8'h03);
        tick();
        checkVal("read_done", {6'd0, ControlEnable, Ibf}, 8'h00);
        checkVal("read_status", StatusWord, 8'h46);

        // Overrun while FULL.
        StbN = 1'b0;
        tick();
        tick();
        StbN = 1'b1;
        tickWatch(8);
        checkVal("refill_ibf_intr", {6'd0, Ibf, Intr}, 8'h03);
        sawLatch = 1'b0;
        StbN = 1'b0;
        tickWatch(2);
        StbN = 1'b1;
        tickWatch(8);
        checkVal("ovr_no_latch", {7'd0, sawLatch}, 8'h00);
        checkVal("ovr_status", StatusWord, 8'hEE);
        ctrlWrite(8'h04);
        checkVal("bsr_clear_status", StatusWord, 8'h26);

        // Mode set while FULL drops the handshake.
        ctrlWrite(8'h90);
        checkVal("m0_status", StatusWord, 8'h02);
        checkVal("m0_hs", {5'd0, Ibf, ObfN, Intr}, 8'h02);
        sawLatch = 1'b0;
        StbN = 1'b0;
        tickWatch(3);
        StbN = 1'b1;
        tickWatch(8);
        checkVal("m0_no_latch", {7'd0, sawLatch}, 8'h00);
        cpuRead();
        checkVal("m0_read_ce", {7'd0, ControlEnable}, 8'h01);
        tick();
        checkVal("m0_read_ce_end", {7'd0, ControlEnable}, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
